// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch PC from sequential, branch, jump
// and jump-register sources, holds one pending redirect across stalls, halts on a misaligned target.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [31:0] id_pc4,
   input  logic        branch,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        redirect,
   output logic        misaligned
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_nxt;
   logic        pend_valid, pend_valid_nxt;
   logic [31:0] pend_tgt, pend_tgt_nxt;
   logic        redirect_nxt, misaligned_nxt, fetch_valid_nxt;
   logic        ev, apply;
   logic [31:0] ev_tgt, apply_tgt;

   assign pc_plus4 = pc + 32'd4;

   // Fresh event from ID, highest-priority source wins; lower ones are dropped.
   always_comb begin
      ev = jr | jump | (branch & branch_taken);
      if (jr)
         ev_tgt = jr_target;
      else if (jump)
         ev_tgt = {id_pc4[31:28], jump_index, 2'b00};
      else
         ev_tgt = id_pc4 + branch_offset;
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      pend_valid_nxt = pend_valid;
      pend_tgt_nxt   = pend_tgt;
      redirect_nxt   = 1'b0;
      misaligned_nxt = misaligned;
      apply          = 1'b0;
      apply_tgt      = ev_tgt;

      case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            if (stall) begin
               if (ev) begin
                  pend_valid_nxt = 1'b1;
                  pend_tgt_nxt   = ev_tgt;
               end
            end else begin
               // A fresh event supersedes a pending one; either way the pending slot empties.
               pend_valid_nxt = 1'b0;
               apply          = ev | pend_valid;
               apply_tgt      = ev ? ev_tgt : pend_tgt;
               if (!apply) begin
                  pc_nxt = pc_plus4;
               end else if (apply_tgt[1:0] != 2'b00) begin
                  state_nxt      = HALT;
                  misaligned_nxt = 1'b1;
               end else begin
                  pc_nxt       = apply_tgt;
                  redirect_nxt = 1'b1;
               end
            end
         end
         HALT: state_nxt = HALT;
         default: state_nxt = BOOT;
      endcase

      fetch_valid_nxt = (state_nxt == RUN);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= BOOT;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         pend_valid  <= 1'b0;
         pend_tgt    <= 32'h0;
         redirect    <= 1'b0;
         misaligned  <= 1'b0;
         fetch_valid <= 1'b0;
      end else begin
         pc          <= pc_nxt;
         pend_valid  <= pend_valid_nxt;
         pend_tgt    <= pend_tgt_nxt;
         redirect    <= redirect_nxt;
         misaligned  <= misaligned_nxt;
         fetch_valid <= fetch_valid_nxt;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a behavioural model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n, stall, branch, branch_taken, jump, jr;
   logic [31:0] id_pc4, branch_offset, jr_target;
   logic [25:0] jump_index;
   logic [31:0] pc, pc_plus4;
   logic        fetch_valid, redirect, misaligned;

   int checks   = 0;
   int failures = 0;

   pc_sequencer #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .id_pc4(id_pc4),
      .branch(branch), .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
      .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
      .redirect(redirect), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what the fetch stage should observe after each edge.
   typedef struct packed {
      logic [31:0] pc;
      logic        booting;
      logic        halted;
      logic        fv;
      logic        redir;
      logic        mis;
      logic        has_pend;
      logic [31:0] pend;
   } model_t;

   model_t m;
   bit     m_ok = 1'b0;

   function automatic model_t step(input model_t s);
      model_t      n;
      logic        has_ev;
      logic [31:0] tgt;
      n       = s;
      n.redir = 1'b0;
      if (!rst_n) begin
         n = '{pc: RST_PC, booting: 1'b1, halted: 1'b0, fv: 1'b0, redir: 1'b0,
               mis: 1'b0, has_pend: 1'b0, pend: 32'h0};
      end else if (s.booting) begin
         n.booting = 1'b0;
         n.fv      = 1'b1;
      end else if (!s.halted) begin
         has_ev = jr || jump || (branch && branch_taken);
         tgt    = jr ? jr_target : jump ? {id_pc4[31:28], jump_index, 2'b00} : id_pc4 + branch_offset;
         if (stall) begin
            if (has_ev) begin
               n.has_pend = 1'b1;
               n.pend     = tgt;
            end
         end else begin
            if (!has_ev && s.has_pend) begin
               has_ev = 1'b1;
               tgt    = s.pend;
            end
            n.has_pend = 1'b0;
            if (!has_ev)
               n.pc = s.pc + 32'd4;
            else if (tgt % 4 != 0) begin
               n.halted = 1'b1;
               n.fv     = 1'b0;
               n.mis    = 1'b1;
            end else begin
               n.pc    = tgt;
               n.redir = 1'b1;
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m <= step(m);
      if (!rst_n) m_ok <= 1'b1;
   end

   always @(posedge clk) begin
      #1;
      if (m_ok) begin
         check("pc", pc, m.pc);
         check("pc_plus4", pc_plus4, m.pc + 32'd4);
         check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m.fv});
         check("redirect", {31'b0, redirect}, {31'b0, m.redir});
         check("misaligned", {31'b0, misaligned}, {31'b0, m.mis});
      end
   end

   task automatic clear_events();
      branch = 0; branch_taken = 0; jump = 0; jr = 0;
      id_pc4 = 0; branch_offset = 0; jump_index = 0; jr_target = 0;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      clear_events();
      stall = 0;
      rst_n = 0;
      repeat (2) cyc();
      check("lit_rst_pc", pc, 32'h0040_0000);
      check("lit_rst_fv", {31'b0, fetch_valid}, 32'd0);
      check("lit_rst_mis", {31'b0, misaligned}, 32'd0);

      rst_n = 1;
      cyc(); check("lit_boot_pc", pc, 32'h0040_0000);
      check("lit_boot_fv", {31'b0, fetch_valid}, 32'd1);
      cyc(); check("lit_seq1", pc, 32'h0040_0004);
      cyc(); check("lit_seq2", pc, 32'h0040_0008);

      // Taken branch back by 16 bytes from id_pc4.
      id_pc4 = 32'h0040_0010; branch_offset = 32'hFFFF_FFF0; branch = 1; branch_taken = 1;
      cyc(); clear_events();
      check("lit_br_pc", pc, 32'h0040_0000);
      check("lit_br_redir", {31'b0, redirect}, 32'd1);
      cyc(); check("lit_br_redir_drop", {31'b0, redirect}, 32'd0);

      id_pc4 = 32'h0040_0010; branch_offset = 32'hFFFF_FFF0; branch = 1; branch_taken = 0;
      cyc(); clear_events();
      check("lit_br_nt_pc", pc, 32'h0040_0008);

      // Priority: jr beats jump and branch.
      jr = 1; jump = 1; branch = 1; branch_taken = 1; jr_target = 32'h0000_1000;
      id_pc4 = 32'h0040_0010; branch_offset = 32'h40; jump_index = 26'h3;
      cyc(); clear_events();
      check("lit_prio_pc", pc, 32'h0000_1000);
      jump = 1; id_pc4 = 32'h1000_0004; jump_index = 26'h000_0040;
      cyc(); clear_events();
      check("lit_jump_pc", pc, 32'h1000_0100);
      check("lit_jump_redir", {31'b0, redirect}, 32'd1);

      // Stall: newer pending jr overwrites older pending jump.
      stall = 1; jump = 1; jump_index = 26'h80;
      cyc(); clear_events(); check("lit_stall1", pc, 32'h1000_0100);
      jr = 1; jr_target = 32'h0000_0300;
      cyc(); clear_events(); check("lit_stall2", pc, 32'h1000_0100);
      cyc(); check("lit_stall3", pc, 32'h1000_0100);
      stall = 0;
      cyc(); check("lit_pend_pc", pc, 32'h0000_0300);
      check("lit_pend_redir", {31'b0, redirect}, 32'd1);
      cyc(); check("lit_pend_after", pc, 32'h0000_0304);

      // Misaligned pending target discarded by a fresh aligned event.
      stall = 1; jr = 1; jr_target = 32'h0000_0002;
      cyc(); clear_events();
      check("lit_latch_nomis", {31'b0, misaligned}, 32'd0);
      stall = 0; jr = 1; jr_target = 32'h0000_0500;
      cyc(); clear_events(); check("lit_fresh_wins", pc, 32'h0000_0500);
      cyc();

      // Misaligned jr halts the sequencer.
      jr = 1; jr_target = 32'h0000_1002;
      cyc(); clear_events();
      check("lit_halt_mis", {31'b0, misaligned}, 32'd1);
      check("lit_halt_fv", {31'b0, fetch_valid}, 32'd0);
      check("lit_halt_pc", pc, 32'h0000_0504);
      jump = 1; jump_index = 26'h80;
      cyc(); clear_events(); check("lit_halt_hold", pc, 32'h0000_0504);
      rst_n = 0;
      cyc(); check("lit_halt_rst_mis", {31'b0, misaligned}, 32'd0);
      check("lit_halt_rst_pc", pc, 32'h0040_0000);
      rst_n = 1;
      cyc();

      // Sequential wrap through 0xFFFF_FFFC.
      jr = 1; jr_target = 32'hFFFF_FFF8;
      cyc(); clear_events(); check("lit_wrap0", pc, 32'hFFFF_FFF8);
      cyc(); check("lit_wrap1", pc, 32'hFFFF_FFFC);
      check("lit_wrap_p4", pc_plus4, 32'h0000_0000);
      cyc(); check("lit_wrap2", pc, 32'h0000_0000);
      check("lit_wrap_mis", {31'b0, misaligned}, 32'd0);

      // Reset discards a pending redirect.
      stall = 1; jump = 1; jump_index = 26'h80;
      cyc(); clear_events();
      rst_n = 0;
      cyc();
      rst_n = 1; stall = 0;
      cyc();
      cyc(); check("lit_rst_pend_pc", pc, 32'h0040_0004);
      check("lit_rst_pend_redir", {31'b0, redirect}, 32'd0);

      cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
